cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Result-side counterpart of the execution-unit wrappers: collects finished results from NUM_UNITS
//  units over their ready-valid result ports and broadcasts one per cycle on the common data bus (CDB).
//  CDB drives the reservation-station operand-update port (valid/rs_id/value) and the GPR/CR0-XER writeback.
//  Sits between all *_wrapper result outputs and the RS update inputs plus the register file.
// PARAMETERS
//  NUM_UNITS    4  number of execution-unit result ports (>=2)
//  RS_ID_WIDTH  5  width of reservation-station tag
// PORTS
//  clk                  in   1                          clock, all logic on rising edge
//  rst                  in   1                          asynchronous, active-low reset
//  unit_valid           in   [0:NUM_UNITS-1]            per-unit result valid
//  unit_ready           out  [0:NUM_UNITS-1]            per-unit result accepted (one-hot or zero)
//  unit_rs_id           in   [NUM_UNITS][0:RS_ID_WIDTH-1] producing RS tag per unit
//  unit_reg_addr        in   [NUM_UNITS][0:4]           destination GPR per unit
//  unit_result          in   [NUM_UNITS][0:31]          result value per unit
//  unit_cr0_xer         in   [NUM_UNITS] cond_exception_t  condition/exception bits per unit
//  update_op_valid      out  1                          CDB broadcast valid (to all RS)
//  update_op_rs_id      out  [0:RS_ID_WIDTH-1]          broadcast tag
//  update_op_value      out  [0:31]                     broadcast value
//  gpr_write_valid      out  1                          GPR write enable (== update_op_valid)
//  gpr_write_addr       out  [0:4]                      GPR write address
//  gpr_write_data       out  [0:31]                     GPR write data (== update_op_value)
//  cr0_xer_out          out  cond_exception_t           CR0/XER update, qualified by update_op_valid
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, cr0_xer_out all-zero, rr pointer = 0; effect immediate, mid-transfer
//    results are dropped (unit keeps valid high and re-offers after reset).
//  - Arbitration: combinational round-robin over unit_valid starting at rr pointer; unit_ready = grant
//    (one-hot, or 0 when no valid). CDB never back-pressures: a valid unit is granted within NUM_UNITS cycles.
//  - Handshake: transfer when unit_valid[i] && unit_ready[i]; unit must hold valid and data stable until granted.
//  - rr pointer: on any transfer, pointer <= (granted index + 1) mod NUM_UNITS (wraps NUM_UNITS-1 -> 0);
//    unchanged in cycles without a transfer.
//  - Latency: 1 cycle. Granted payload registered; broadcast appears the cycle after the handshake for
//    exactly one cycle; update_op_valid deasserts next cycle unless another transfer occurred.
//  - Back-to-back: one broadcast per cycle sustained; same unit may transfer every cycle if sole requester.
//  - Simultaneous: units not granted see unit_ready=0 and keep waiting; no result lost or duplicated.
//  - Tag feedback: a broadcast may wake an RS that issues into a unit in the same cycle; no combinational
//    path from unit_valid to update_op_* (registered boundary).
//  - No arithmetic on payload; fields passed verbatim.
// CONFIGURATION
//  CDB_PERF_CNT_EN defined: adds outputs perf_broadcasts [0:31] (count of broadcasts) and perf_conflicts
//   [0:31] (cycles with >=2 unit_valid); both reset to 0, saturate at 2^32-1. Absent: ports and counters omitted.
// STRUCTURE
//  - ppc_types: add cdb_result_t {rs_id, reg_addr, value, cr0_xer} shared by wrappers and this block.
//  - Sub-module rr_arbiter #(N): valid vector + pointer in, one-hot grant + encoded index out.
//  - Top: rr_arbiter, payload mux, output register, pointer register, optional counters.
// TESTING
//  1 Reset: rst low with valids high -> all outputs 0, unit_ready still combinational from pointer 0.
//  2 Single unit 2 valid, rs_id=7, addr=3, value=0xDEADBEEF -> ready[2]=1 same cycle; next cycle update_op_valid=1,
//    rs_id=7, gpr_write_addr=3, data=0xDEADBEEF; following cycle valid=0.
//  3 All 4 units valid continuously from pointer 0 -> grants 0,1,2,3,0 on consecutive cycles, 5 broadcasts.
//  4 Pointer wrap: last grant unit 3, then units 0 and 3 valid -> unit 0 granted first, unit 3 next cycle.
//  5 Async reset asserted mid-burst -> outputs 0 immediately, pointer 0; after release unit 0 granted first.
//  6 CDB_PERF_CNT_EN: 3 cycles with 2 valids, 6 broadcasts -> perf_conflicts=3... (exact per bench stimulus),
//    perf_broadcasts equals observed update_op_valid count.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared result-bus types for the execution-unit wrappers and the CDB arbiter.
// Holds the condition/exception bits, the CDB result record and a saturating counter helper.
package cdb_arbiter_pkg;

    localparam int CDB_RS_ID_W    = 5;
    localparam int CDB_REG_ADDR_W = 5;
    localparam int CDB_DATA_W     = 32;

    typedef struct packed {
        logic cr0_lt;
        logic cr0_gt;
        logic cr0_eq;
        logic cr0_so;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;

    typedef struct packed {
        logic [0:CDB_RS_ID_W-1]    rs_id;
        logic [0:CDB_REG_ADDR_W-1] reg_addr;
        logic [0:CDB_DATA_W-1]     value;
        cond_exception_t           cr0_xer;
    } cdb_result_t;

    function automatic logic [0:31] sat_inc32(input logic [0:31] cnt);
        return (&cnt) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after the pointer wins.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [0:N-1]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [0:N-1]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // NOTE: every output gets a default before the search loop, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && valid_i[cand]) begin
                any_o          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one finished unit result per cycle and broadcasts it registered.
// Optional macro CDB_PERF_CNT_EN adds saturating broadcast and conflict counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:NUM_UNITS-1]   unit_valid,
    output logic [0:NUM_UNITS-1]   unit_ready,
    input  logic [0:RS_ID_WIDTH-1] unit_rs_id    [NUM_UNITS],
    input  logic [0:4]             unit_reg_addr [NUM_UNITS],
    input  logic [0:31]            unit_result   [NUM_UNITS],
    input  cond_exception_t        unit_cr0_xer  [NUM_UNITS],
    output logic                   update_op_valid,
    output logic [0:RS_ID_WIDTH-1] update_op_rs_id,
    output logic [0:31]            update_op_value,
    output logic                   gpr_write_valid,
    output logic [0:4]             gpr_write_addr,
    output logic [0:31]            gpr_write_data,
    output cond_exception_t        cr0_xer_out
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [0:31]            perf_broadcasts,
    output logic [0:31]            perf_conflicts
`endif
);

    localparam int IDX_W = $clog2(NUM_UNITS);

    typedef struct packed {
        logic [0:RS_ID_WIDTH-1] rs_id;
        logic [0:4]             reg_addr;
        logic [0:31]            value;
        cond_exception_t        cr0_xer;
    } bcast_t;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             valid_q;
    bcast_t           bcast_q, bcast_d;

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_rr (
        .valid_i (unit_valid),
        .ptr_i   (ptr_q),
        .grant_o (unit_ready),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Idle cycles load zeros, so the payload outputs are already qualified by update_op_valid.
    always_comb begin
        bcast_d = '0;
        ptr_d   = ptr_q;
        if (grant_any) begin
            bcast_d.rs_id    = unit_rs_id[grant_idx];
            bcast_d.reg_addr = unit_reg_addr[grant_idx];
            bcast_d.value    = unit_result[grant_idx];
            bcast_d.cr0_xer  = unit_cr0_xer[grant_idx];
            ptr_d = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            bcast_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= grant_any;
            bcast_q <= bcast_d;
        end
    end

    assign update_op_valid = valid_q;
    assign update_op_rs_id = bcast_q.rs_id;
    assign update_op_value = bcast_q.value;
    assign gpr_write_valid = valid_q;
    assign gpr_write_addr  = bcast_q.reg_addr;
    assign gpr_write_data  = bcast_q.value;
    assign cr0_xer_out     = bcast_q.cr0_xer;

`ifdef CDB_PERF_CNT_EN
    logic [0:31] bcast_cnt_q, conflict_cnt_q;
    logic        conflict;

    assign conflict = ($countones(unit_valid) >= 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcast_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (valid_q)  bcast_cnt_q    <= sat_inc32(bcast_cnt_q);
            if (conflict) conflict_cnt_q <= sat_inc32(conflict_cnt_q);
        end
    end

    assign perf_broadcasts = bcast_cnt_q;
    assign perf_conflicts  = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 units); perf counters checked when CDB_PERF_CNT_EN is set.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [0:N-1]    unit_valid = '0;
    logic [0:N-1]    unit_ready;
    logic [0:RW-1]   unit_rs_id    [N];
    logic [0:4]      unit_reg_addr [N];
    logic [0:31]     unit_result   [N];
    cond_exception_t unit_cr0_xer  [N];
    logic            update_op_valid;
    logic [0:RW-1]   update_op_rs_id;
    logic [0:31]     update_op_value;
    logic            gpr_write_valid;
    logic [0:4]      gpr_write_addr;
    logic [0:31]     gpr_write_data;
    cond_exception_t cr0_xer_out;
`ifdef CDB_PERF_CNT_EN
    logic [0:31]     perf_broadcasts;
    logic [0:31]     perf_conflicts;
`endif

    int checks = 0;
    int errors = 0;
    int obs    = 0;

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .unit_valid      (unit_valid),
        .unit_ready      (unit_ready),
        .unit_rs_id      (unit_rs_id),
        .unit_reg_addr   (unit_reg_addr),
        .unit_result     (unit_result),
        .unit_cr0_xer    (unit_cr0_xer),
        .update_op_valid (update_op_valid),
        .update_op_rs_id (update_op_rs_id),
        .update_op_value (update_op_value),
        .gpr_write_valid (gpr_write_valid),
        .gpr_write_addr  (gpr_write_addr),
        .gpr_write_data  (gpr_write_data),
        .cr0_xer_out     (cr0_xer_out)
`ifdef CDB_PERF_CNT_EN
        ,
        .perf_broadcasts (perf_broadcasts),
        .perf_conflicts  (perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:N-1] oh(input int u);
        logic [0:N-1] v;
        v    = '0;
        v[u] = 1'b1;
        return v;
    endfunction

    // Unit i carries tag 16+i, GPR 8+i, value A0000000+i, cr0/xer bits i+1.
    task automatic load_burst();
        for (int i = 0; i < N; i++) begin
            unit_rs_id[i]    = RW'(16 + i);
            unit_reg_addr[i] = 5'(8 + i);
            unit_result[i]   = 32'hA000_0000 + 32'(i);
            unit_cr0_xer[i]  = cond_exception_t'(7'(i + 1));
        end
    endtask

    task automatic expect_bcast(input string tag, input int u);
        check({tag, "_valid"}, 64'(update_op_valid), 64'd1);
        check({tag, "_rs_id"}, 64'(update_op_rs_id), 64'(16 + u));
        check({tag, "_value"}, 64'(update_op_value), 64'(32'hA000_0000 + 32'(u)));
    endtask

    initial begin
        int exp_grant[5];
        exp_grant = '{0, 1, 2, 3, 0};

        // 1: reset held with every unit requesting
        load_burst();
        unit_valid = '1;
        repeat (2) tick();
        check("rst_valid", 64'(update_op_valid), 64'd0);
        check("rst_gpr_we", 64'(gpr_write_valid), 64'd0);
        check("rst_rs_id", 64'(update_op_rs_id), 64'd0);
        check("rst_value", 64'(update_op_value), 64'd0);
        check("rst_gpr_addr", 64'(gpr_write_addr), 64'd0);
        check("rst_cr0", 64'(cr0_xer_out), 64'd0);
        check("rst_ready", 64'(unit_ready), 64'(oh(0)));
`ifdef CDB_PERF_CNT_EN
        check("rst_perf_b", 64'(perf_broadcasts), 64'd0);
        check("rst_perf_c", 64'(perf_conflicts), 64'd0);
`endif
        unit_valid = '0;
        rst = 1'b1;
        #1;
        check("idle_ready", 64'(unit_ready), 64'd0);
        tick();
        check("idle_valid", 64'(update_op_valid), 64'd0);

        // 2: single result from unit 2
        unit_rs_id[2]    = 5'd7;
        unit_reg_addr[2] = 5'd3;
        unit_result[2]   = 32'hDEAD_BEEF;
        unit_cr0_xer[2]  = cond_exception_t'(7'b1010011);
        unit_valid       = oh(2);
        #1;
        check("u2_ready", 64'(unit_ready), 64'(oh(2)));
        check("u2_no_comb_path", 64'(update_op_valid), 64'd0);
        tick();
        unit_valid = '0;
        check("u2_valid", 64'(update_op_valid), 64'd1);
        check("u2_gpr_we", 64'(gpr_write_valid), 64'd1);
        check("u2_rs_id", 64'(update_op_rs_id), 64'd7);
        check("u2_addr", 64'(gpr_write_addr), 64'd3);
        check("u2_value", 64'(update_op_value), 64'hDEAD_BEEF);
        check("u2_data", 64'(gpr_write_data), 64'hDEAD_BEEF);
        check("u2_cr0", 64'(cr0_xer_out), 64'b1010011);
        tick();
        check("u2_drop", 64'(update_op_valid), 64'd0);

        // 3: all units valid from pointer 0
        rst = 1'b0;
        #1;
        rst = 1'b1;
        load_burst();
        unit_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("all_ready%0d", k), 64'(unit_ready), 64'(oh(exp_grant[k])));
            tick();
            expect_bcast($sformatf("all_b%0d", k), exp_grant[k]);
            check($sformatf("all_addr%0d", k), 64'(gpr_write_addr), 64'(8 + exp_grant[k]));
        end

        // 4: pointer wrap after a grant to unit 3
        unit_valid = oh(3);
        tick();
        expect_bcast("wrap_u3", 3);
        unit_valid = oh(0) | oh(3);
        #1;
        check("wrap_ready0", 64'(unit_ready), 64'(oh(0)));
        tick();
        expect_bcast("wrap_b0", 0);
        unit_valid = oh(3);
        #1;
        check("wrap_ready3", 64'(unit_ready), 64'(oh(3)));
        tick();
        expect_bcast("wrap_b3", 3);
        unit_valid = '0;
        tick();

        // 5: asynchronous reset in the middle of a burst
        rst = 1'b0;
        #1;
        rst = 1'b1;
        unit_valid = '1;
        tick();
        expect_bcast("burst_b0", 0);
        tick();
        expect_bcast("burst_b1", 1);
        rst = 1'b0;
        #1;
        check("async_valid", 64'(update_op_valid), 64'd0);
        check("async_gpr_we", 64'(gpr_write_valid), 64'd0);
        check("async_data", 64'(gpr_write_data), 64'd0);
        check("async_cr0", 64'(cr0_xer_out), 64'd0);
        check("async_ready", 64'(unit_ready), 64'(oh(0)));
        tick();
        check("async_hold", 64'(update_op_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("rel_ready", 64'(unit_ready), 64'(oh(0)));
        tick();
        expect_bcast("rel_b0", 0);

        // 6: two contenders for three cycles, then unit 2 back-to-back alone
        unit_valid = '0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        unit_valid = oh(0) | oh(1);
        tick();
        if (update_op_valid) obs++;
        expect_bcast("pc_b0", 0);
        tick();
        if (update_op_valid) obs++;
        expect_bcast("pc_b1", 1);
        tick();
        if (update_op_valid) obs++;
        expect_bcast("pc_b2", 0);
        unit_valid = oh(2);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (update_op_valid) obs++;
            expect_bcast($sformatf("b2b_%0d", k), 2);
        end
        unit_valid = '0;
        tick();
        if (update_op_valid) obs++;
        check("b2b_drop", 64'(update_op_valid), 64'd0);
        tick();
        check("obs_bcasts", 64'(obs), 64'd6);
`ifdef CDB_PERF_CNT_EN
        check("perf_broadcasts", 64'(perf_broadcasts), 64'd6);
        check("perf_conflicts", 64'(perf_conflicts), 64'd3);
        check("perf_vs_obs", 64'(perf_broadcasts), 64'(obs));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
